// File: rtl/cascaded_counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cascaded_counter_sequencer_pkg
// Shared definitions for the counter-chip sequencer:
//   - command op codes (CLEAR/LOAD/UP/DOWN)
//   - chip mode-line encodings (S[1:0])
//   - sequencer state enum
//   - helper mapping a count direction to its chip mode
// -----------------------------------------------------------------------------
package cascaded_counter_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_UP    = 2'd2,
        OP_DOWN  = 2'd3
    } op_e;

    // Chip mode lines S[1:0]
    localparam logic [1:0] MODE_CLR  = 2'b00;   // asynchronous clear
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;   // ignores ENP/ENT
    localparam logic [1:0] MODE_UP   = 2'b11;   // doubles as hold when disabled

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic [1:0] step_mode(input logic up);
        return up ? MODE_UP : MODE_DOWN;
    endfunction

endpackage

// File: rtl/cascaded_counter_sequencer_if.sv
// -----------------------------------------------------------------------------
// cascaded_counter_sequencer_if
// Command handshake bundle for the sequencer.
//   cmd_valid  : command offered (master -> slave)
//   cmd_ready  : sequencer idle, command accepted on valid&ready (slave -> master)
//   cmd_op     : op code, see op_e
//   cmd_steps  : step count for UP/DOWN
//   cmd_data   : load value for LOAD
// -----------------------------------------------------------------------------
interface cascaded_counter_sequencer_if #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_steps;
    logic [WIDTH-1:0]  cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_steps, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_steps, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/cascaded_counter_sequencer_timer.sv
// -----------------------------------------------------------------------------
// step_down_timer
// Loadable STEP_W-bit down-counter tracking the remaining count steps.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : number of steps to run
//   dec_i      : decrement by one this edge
//   last_o     : the current edge is the final step (count == 1)
// -----------------------------------------------------------------------------
module step_down_timer #(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [STEP_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              last_o
);

    logic [STEP_W-1:0] cnt_q;
    logic [STEP_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == STEP_W'(1));

endmodule

// File: rtl/cascaded_counter_sequencer.sv
// -----------------------------------------------------------------------------
// cascaded_counter_sequencer
// Command-driven sequencer in front of a cascade of WIDTH/8 8-bit loadable
// up/down counter chips. Drives the shared mode lines, the enables and the
// parallel load data cycle-accurately and keeps a shadow of the count.
//   clk, rst   : clock shared with the chips, synchronous active-high reset
//   cmd        : command handshake (slave side)
//   ctr_s      : chip mode lines, registered
//   ctr_enp_n  : ENP to all chips, registered
//   ctr_ent_n  : ENT to the lowest chip, registered
//   ctr_d      : parallel load data, registered
//   shadow     : tracked counter value
//   busy       : command in progress (~cmd_ready)
//   done       : one-cycle pulse on completion
//   wrap       : sticky wrap-around flag, cleared on the next accept
// -----------------------------------------------------------------------------
module cascaded_counter_sequencer
    import cascaded_counter_sequencer_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    cascaded_counter_sequencer_if.slave  cmd,
    output logic [1:0]                   ctr_s,
    output logic                         ctr_enp_n,
    output logic                         ctr_ent_n,
    output logic [WIDTH-1:0]             ctr_d,
    output logic [WIDTH-1:0]             shadow,
    output logic                         busy,
    output logic                         done,
    output logic                         wrap
);

    state_e           state_q;
    logic [1:0]       ctr_s_q;
    logic             enp_n_q;
    logic             ent_n_q;
    logic [WIDTH-1:0] ctr_d_q;
    logic [WIDTH-1:0] shadow_q;
    logic             wrap_q;
    logic             done_q;
    logic             up_q;

    logic             accept;
    logic             is_count_op;
    logic             steps_nz;
    logic             step_last;
    op_e              op;

    assign op          = op_e'(cmd.cmd_op);
    assign accept      = cmd.cmd_valid && (state_q == ST_IDLE);
    assign is_count_op = (op == OP_UP) || (op == OP_DOWN);
    assign steps_nz    = (cmd.cmd_steps != '0);

    step_down_timer #(
        .STEP_W (STEP_W)
    ) u_remaining (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept && is_count_op && steps_nz),
        .load_val_i (cmd.cmd_steps),
        .dec_i      (state_q == ST_STEP),
        .last_o     (step_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // Holding S=00 clears the chips, keeping them consistent with shadow=0.
            state_q  <= ST_IDLE;
            ctr_s_q  <= MODE_CLR;
            enp_n_q  <= 1'b1;
            ent_n_q  <= 1'b1;
            ctr_d_q  <= '0;
            shadow_q <= '0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Hold: count mode with both enables inactive.
                    ctr_s_q <= MODE_UP;
                    enp_n_q <= 1'b1;
                    ent_n_q <= 1'b1;
                    if (accept) begin
                        wrap_q <= 1'b0;
                        case (op)
                            OP_CLEAR: begin
                                ctr_s_q <= MODE_CLR;
                                state_q <= ST_CLR;
                            end
                            OP_LOAD: begin
                                ctr_s_q <= MODE_LOAD;
                                ctr_d_q <= cmd.cmd_data;
                                state_q <= ST_LOAD;
                            end
                            default: begin
                                if (steps_nz) begin
                                    ctr_s_q <= step_mode(op == OP_UP);
                                    enp_n_q <= 1'b0;
                                    ent_n_q <= 1'b0;
                                    up_q    <= (op == OP_UP);
                                    state_q <= ST_STEP;
                                end else begin
                                    // Zero-step count: nothing to drive, finish at once.
                                    done_q  <= 1'b1;
                                    state_q <= ST_DONE;
                                end
                            end
                        endcase
                    end
                end
                ST_CLR: begin
                    shadow_q <= '0;
                    ctr_s_q  <= MODE_UP;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_LOAD: begin
                    // Chips capture ctr_d on this same edge.
                    shadow_q <= ctr_d_q;
                    ctr_s_q  <= MODE_UP;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_STEP: begin
                    if (up_q) begin
                        shadow_q <= shadow_q + WIDTH'(1);
                        if (&shadow_q) wrap_q <= 1'b1;
                    end else begin
                        shadow_q <= shadow_q - WIDTH'(1);
                        if (shadow_q == '0) wrap_q <= 1'b1;
                    end
                    if (step_last) begin
                        enp_n_q <= 1'b1;
                        ent_n_q <= 1'b1;
                        ctr_s_q <= MODE_UP;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign ctr_s         = ctr_s_q;
    assign ctr_enp_n     = enp_n_q;
    assign ctr_ent_n     = ent_n_q;
    assign ctr_d         = ctr_d_q;
    assign shadow        = shadow_q;
    assign done          = done_q;
    assign wrap          = wrap_q;

endmodule
